ice40_lc_cfg_seq: RTL and testbench
===================================

# ice40_lc_cfg_seq

Runtime configuration sequencer for a chain of ICESTORM_LC-style logic cells whose LUT contents and mode flags are held in a serial shift chain. A host writes per-cell configuration words into a shadow store over a valid/ready port. On `start`, the block serialises the whole store onto the chain, then pulses a latch strobe so every cell adopts its new configuration in the same cycle. It sits between the fabric's control bus and the configurable logic-cell array.

## Interface

- `NUM_CELLS`, default 8: number of cells in the chain; legal range 1..64.
- `ADDR_W`, default 6: width of `cfg_addr`; requires 2^ADDR_W >= NUM_CELLS.
- Derived, fixed: CFG_BITS = 21 bits per cell; TOTAL = NUM_CELLS*21.

- `CLK` in 1: single clock; all state updates on the rising edge.
- `SR` in 1: reset, synchronous, active-high.
- `cfg_valid` in 1: host write request.
- `cfg_ready` out 1: block can accept a write.
- `cfg_addr` in ADDR_W: target cell index.
- `cfg_data` in 21: [15:0] LUT_INIT, [16] NEG_CLK, [17] CARRY_ENABLE, [18] DFF_ENABLE, [19] SET_NORESET, [20] ASYNC_SR.
- `start` in 1: request a program cycle.
- `busy` out 1: program cycle in progress.
- `done` out 1: single-cycle pulse when the program cycle completes.
- `err` out 1: sticky; a write addressed to `cfg_addr >= NUM_CELLS`.
- `err_clr` in 1: clears `err`.
- `chain_en` out 1: shift enable for the cell chain.
- `chain_d` out 1: serial data into the chain.
- `chain_latch` out 1: single-cycle update strobe to all cells.

## Operation

- Shadow store holds NUM_CELLS × 21 bits. `SR` clears it to all zeros.
- Write handshake: a write occurs on a cycle with `cfg_valid && cfg_ready`. An in-range address writes the word. An out-of-range address discards the word and sets `err`.
- `cfg_ready` = !busy && !SR.
- FSM states: IDLE, SHIFT, LATCH, DONE.
  - IDLE → SHIFT when `start`. The bit counter loads 0.
  - SHIFT: `chain_en`=1 for each bit. After the TOTAL-th bit, go to LATCH.
  - LATCH: `chain_latch`=1 for one cycle, then go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `busy` = state != IDLE.
- Shift order:
  - Cell index NUM_CELLS-1 first, down to cell 0.
  - Within a cell, bit 20 first, down to bit 0.
  - Cell 0 bit 0 is the last bit shifted.
- Store snapshot: a write is never accepted while busy, so the shifted image equals the store at the `start` cycle.
- `start` while busy is ignored; it is not queued.
- `start` and a write in the same IDLE cycle: the write is committed first, and the shifted image includes it.
- `err_clr` and an out-of-range write in the same cycle: `err` ends at 1 (set wins).
- `SR` during any state:
  - Next state is IDLE.
  - Store, counter and `err` are cleared.
  - `chain_en`, `chain_latch` and `done` are 0 from the next cycle.
  - No latch pulse is issued for a partial shift.

## Timing

- Reset values: `cfg_ready`=0 while `SR` is high and 1 in the first cycle after it falls. `busy`, `done`, `err`, `chain_en`, `chain_d` and `chain_latch` are all 0.
- All outputs are registered except `cfg_ready`, which is combinational from state and `SR`.
- `start` sampled at edge t gives `chain_en`=1 for cycles t+1 .. t+TOTAL.
- `chain_d` is valid in the same cycle as `chain_en`. The chain samples it at the following edge.
- `chain_latch`=1 in cycle t+TOTAL+1.
- `done`=1 in cycle t+TOTAL+2.
- `busy`=1 in cycles t+1 .. t+TOTAL+2.
- A new `start` is accepted no earlier than cycle t+TOTAL+3.
- Write latency: data is visible in the store at the edge after acceptance. Throughput is one write per cycle.
- `chain_d`=0 whenever `chain_en`=0.

## Test plan

- Reset check (NUM_CELLS=2): hold `SR` 3 cycles and release. Required: all outputs 0 while `SR` is high, `cfg_ready`=1 on the next cycle. `start` then shifts 42 zero bits, with `chain_latch` in cycle 43 and `done` in cycle 44.
- Program image (NUM_CELLS=2):
  - Write cell0=21'h0_0006 and cell1=21'h1F_FFFF, then `start`.
  - Required `chain_d` sequence: 21 ones, then 0×18, 1, 1, 0 (cell0 bits 20..0).
  - `chain_latch` asserts exactly once, after bit 42.
- Handshake under busy: drive `cfg_valid`=1 with cell0=21'h0_FFFF mid-SHIFT. Required: `cfg_ready`=0 and the shifted image is unchanged. The write is accepted in the first IDLE cycle after `done`; a second program cycle then shifts 0xFFFF for cell0.
- Same-cycle write + start: write cell1=21'h10_0001 with `start` in the same cycle. Required: the first 21 `chain_d` bits are 1, 0×19, 1.
- Error path: write addr=5 with NUM_CELLS=2. Required: `err`=1 next cycle and the store unchanged. `err_clr` alone clears it. Same-cycle `err_clr` plus a bad write leaves `err`=1.
- Reset mid-shift: assert `SR` at bit 10 of SHIFT. Required: `chain_en`=0 next cycle, no `chain_latch` and no `done`. The store reads back as zeros on the next program cycle.

Source files
------------

// File: rtl/ice40_lc_cfg_seq_if.sv
// ----------------------------------------------------------------------------
// ice40_lc_cfg_seq_if
//   Host-side configuration write port of the logic-cell config sequencer.
//   master : host (drives cfg_valid / cfg_addr / cfg_data, sees cfg_ready)
//   slave  : sequencer (accepts the write, drives cfg_ready)
//   A word is transferred on every rising edge where cfg_valid && cfg_ready.
// ----------------------------------------------------------------------------
interface ice40_lc_cfg_seq_if #(
    parameter int ADDR_W = 6
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [20:0]       cfg_data;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/ice40_lc_cfg_seq.sv
// ----------------------------------------------------------------------------
// ice40_lc_cfg_seq
//   Runtime configuration sequencer for a serial chain of logic cells. The
//   host fills a shadow store (one 21-bit word per cell) over the cfg port;
//   on start the whole store is shifted onto the chain, MSB cell / MSB bit
//   first, followed by a one-cycle latch strobe and a one-cycle done pulse.
//
// Ports
//   CLK, SR      : clock, synchronous active-high reset
//   cfg          : write port (slave side), cfg_ready = idle && !SR
//   start        : request a program cycle (ignored while busy)
//   busy, done   : program cycle in progress / completion pulse
//   err, err_clr : sticky out-of-range write flag and its clear
//   chain_en     : chain shift enable, chain_d valid in the same cycle
//   chain_d      : serial chain data (0 whenever chain_en is 0)
//   chain_latch  : one-cycle strobe making all cells adopt the new image
// ----------------------------------------------------------------------------
module ice40_lc_cfg_seq #(
    parameter int NUM_CELLS = 8,
    parameter int ADDR_W    = 6
) (
    input  logic                  CLK,
    input  logic                  SR,
    ice40_lc_cfg_seq_if.slave     cfg,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  err_clr,
    output logic                  chain_en,
    output logic                  chain_d,
    output logic                  chain_latch
);

    localparam int CFG_BITS = 21;
    localparam int TOTAL    = NUM_CELLS * CFG_BITS;
    // TOTAL is never a power of two, so this also covers the counter range.
    localparam int IDX_W    = $clog2(TOTAL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] bit_idx;
    // Cell i occupies bits [i*21 +: 21]; the top bit is the first one shifted.
    logic [TOTAL-1:0] store_q, store_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             chain_en_q, chain_en_d;
    logic             chain_d_q, chain_d_d;
    logic             chain_latch_q, chain_latch_d;

    logic             wr_en;
    logic             addr_ok;

    // cfg_ready is the only combinational output.
    assign cfg.cfg_ready = (state_q == ST_IDLE) && !SR;
    assign wr_en         = cfg.cfg_valid && cfg.cfg_ready;
    assign addr_ok       = int'(cfg.cfg_addr) < NUM_CELLS;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        store_d       = store_q;
        err_d         = err_q;
        done_d        = 1'b0;
        chain_en_d    = 1'b0;
        chain_d_d     = 1'b0;
        chain_latch_d = 1'b0;
        bit_idx       = '0;

        // Writes only happen in IDLE (cfg_ready), so the image cannot change
        // under a running shift.
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (wr_en && addr_ok && int'(cfg.cfg_addr) == i) begin
                store_d[i*CFG_BITS +: CFG_BITS] = cfg.cfg_data;
            end
        end

        // Set has priority over clear.
        if (err_clr)           err_d = 1'b0;
        if (wr_en && !addr_ok) err_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = '0;
                    chain_en_d = 1'b1;
                    // store_d, so a same-cycle write is part of the image.
                    chain_d_d  = store_d[TOTAL-1];
                end
            end
            ST_SHIFT: begin
                // cnt_q is the index of the bit currently on chain_d.
                if (cnt_q == IDX_W'(TOTAL - 1)) begin
                    state_d       = ST_LATCH;
                    chain_latch_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    bit_idx    = IDX_W'(TOTAL - 1) - cnt_d;
                    chain_en_d = 1'b1;
                    chain_d_d  = store_q[bit_idx];
                end
            end
            ST_LATCH: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (SR) begin
            // The shadow store is architecturally cleared by reset, so it is
            // a reset flop array rather than an uninitialised RAM.
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            store_q       <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            chain_en_q    <= 1'b0;
            chain_d_q     <= 1'b0;
            chain_latch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            store_q       <= store_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            chain_en_q    <= chain_en_d;
            chain_d_q     <= chain_d_d;
            chain_latch_q <= chain_latch_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign chain_en    = chain_en_q;
    assign chain_d     = chain_d_q;
    assign chain_latch = chain_latch_q;

endmodule

// File: tb/tb_ice40_lc_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_ice40_lc_cfg_seq
//   Directed bench for ice40_lc_cfg_seq with NUM_CELLS=2 (42-bit image).
//   Captured chain images are packed first-bit-as-MSB, so an expected image
//   is simply {cell1, cell0}.
// ----------------------------------------------------------------------------
module tb_ice40_lc_cfg_seq;

    localparam int NUM_CELLS = 2;
    localparam int ADDR_W    = 6;
    localparam int TOTAL     = NUM_CELLS * 21;

    logic CLK = 1'b0;
    logic SR;
    logic start;
    logic busy, done, err, err_clr;
    logic chain_en, chain_d, chain_latch;

    int checks   = 0;
    int failures = 0;

    ice40_lc_cfg_seq_if #(.ADDR_W(ADDR_W)) cfg_if ();

    ice40_lc_cfg_seq #(
        .NUM_CELLS (NUM_CELLS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .CLK         (CLK),
        .SR          (SR),
        .cfg         (cfg_if),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_clr     (err_clr),
        .chain_en    (chain_en),
        .chain_d     (chain_d),
        .chain_latch (chain_latch)
    );

    always #5 CLK = ~CLK;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [ADDR_W-1:0] addr, input logic [20:0] data);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = addr;
        cfg_if.cfg_data  = data;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // One full program cycle. start is raised here; a caller may already have
    // cfg_valid up for the same cycle. With busy_write, a cell0 write of
    // 21'h0_FFFF (and a stray start) is attempted mid-shift and held.
    task automatic run_prog(input logic [TOTAL-1:0] exp_img, input bit busy_write, input string tag);
        logic [TOTAL-1:0] img;
        bit en_ok, busy_ok;
        int lat_cnt, done_cnt;
        img = '0; en_ok = 1'b1; busy_ok = 1'b1; lat_cnt = 0; done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        for (int k = 0; k < TOTAL; k++) begin
            en_ok   &= (chain_en === 1'b1);
            busy_ok &= (busy === 1'b1);
            lat_cnt  += int'(chain_latch === 1'b1);
            done_cnt += int'(done === 1'b1);
            img = {img[TOTAL-2:0], chain_d};
            if (busy_write && k == 5)  start = 1'b1;
            if (busy_write && k == 6)  start = 1'b0;
            if (busy_write && k == 10) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_addr  = '0;
                cfg_if.cfg_data  = 21'h0_FFFF;
                #1;
                check({tag, " ready_low_busy"}, cfg_if.cfg_ready, 1'b0);
            end
            tick();
        end
        check({tag, " image"},        img, exp_img);
        check({tag, " en_all_bits"},  en_ok, 1'b1);
        check({tag, " busy_shift"},   busy_ok, 1'b1);
        check({tag, " no_early_ctl"}, lat_cnt + done_cnt, 0);
        // cycle t+TOTAL+1
        check({tag, " latch"},        chain_latch, 1'b1);
        check({tag, " en_off_latch"}, {chain_en, chain_d, done}, 3'b000);
        tick();
        // cycle t+TOTAL+2
        check({tag, " done"},         {done, chain_latch, busy}, 3'b101);
        tick();
        // cycle t+TOTAL+3: back in IDLE
        check({tag, " idle"},         {busy, done, chain_latch, chain_en}, 4'b0000);
        check({tag, " ready_idle"},   cfg_if.cfg_ready, 1'b1);
    endtask

    initial begin
        int cnt;
        SR = 1'b1; start = 1'b0; err_clr = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;

        // ---- reset ----
        repeat (3) tick();
        check("rst outputs", {busy, done, err, chain_en, chain_d, chain_latch}, 6'b0);
        check("rst ready", cfg_if.cfg_ready, 1'b0);
        SR = 1'b0;
        #1;
        check("ready after rst", cfg_if.cfg_ready, 1'b1);
        tick();
        run_prog('0, 1'b0, "zero");

        // ---- program image, plus write/start attempted while busy ----
        write(6'd0, 21'h0_0006);
        write(6'd1, 21'h1F_FFFF);
        run_prog({21'h1F_FFFF, 21'h0_0006}, 1'b1, "img");
        // cfg_valid is still held: accepted at the end of this first IDLE cycle
        tick();
        cfg_if.cfg_valid = 1'b0;
        check("stray start ignored", busy, 1'b0);
        run_prog({21'h1F_FFFF, 21'h0_FFFF}, 1'b0, "post_busy_wr");

        // ---- same-cycle write + start ----
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = 6'd1;
        cfg_if.cfg_data  = 21'h10_0001;
        run_prog({21'h10_0001, 21'h0_FFFF}, 1'b0, "wr_start");

        // ---- error path ----
        write(6'd5, 21'h1F_FFFF);
        check("err set", err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err clr", err, 1'b0);
        err_clr = 1'b1;
        write(6'd5, 21'h1F_FFFF);
        err_clr = 1'b0;
        check("err set wins", err, 1'b1);
        run_prog({21'h10_0001, 21'h0_FFFF}, 1'b0, "err_store");
        check("err sticky", err, 1'b1);

        // ---- reset mid-shift (err still set, store non-zero) ----
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("pre_sr shifting", chain_en, 1'b1);
        SR = 1'b1;
        tick();
        check("sr chain_en", chain_en, 1'b0);
        check("sr outputs", {busy, done, err, chain_latch, chain_d}, 5'b0);
        check("sr ready", cfg_if.cfg_ready, 1'b0);
        SR = 1'b0;
        #1;
        check("sr ready release", cfg_if.cfg_ready, 1'b1);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            cnt += int'(chain_latch === 1'b1) + int'(done === 1'b1) + int'(busy === 1'b1);
        end
        check("sr no latch/done", cnt, 0);
        run_prog('0, 1'b0, "sr_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
